// File: rtl/loudness_scan_tracker.sv
// Angle-scan loudness tracker: averages 2^AVG_LOG2 samples per angle, steps a rotator
// through NAngles positions and keeps the loudest angle of the scan.
module loudness_scan_tracker #(
  parameter int W        = 41,
  parameter int NAngles  = 360,
  parameter int AVG_LOG2 = 2,
  parameter int AW       = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          continuous,
  input  logic          loudness_valid,
  input  logic [W-1:0]  loudness,
  input  logic          step_ack,
  output logic          step_req,
  output logic [AW-1:0] angle_index,
  output logic          avg_valid,
  output logic [W-1:0]  avg_loudness,
  output logic [AW-1:0] peak_angle,
  output logic [W-1:0]  peak_loudness,
  output logic          busy,
  output logic          done
);

  localparam int AccW = W + AVG_LOG2;
  localparam int CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] LastCnt   = CntW'((1 << AVG_LOG2) - 1);
  localparam logic [AW-1:0]   LastAngle = AW'(NAngles - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [AccW-1:0] acc;
  logic [CntW-1:0] cnt;

  logic [AccW-1:0] acc_sum_p0;
  logic [W-1:0]    avg_p0;
  logic            last_sample_p0;

  // Accumulator carries AVG_LOG2 guard bits, so the shifted sum always fits in W.
  function automatic logic [W-1:0] trunc_avg(input logic [AccW-1:0] sum);
    logic [AccW-1:0] shifted;
    shifted = sum >> AVG_LOG2;
    return shifted[W-1:0];
  endfunction

  // Stage p0: combinational sum including the sample presented this cycle
  always_comb begin
    acc_sum_p0     = acc + AccW'(loudness);
    avg_p0         = trunc_avg(acc_sum_p0);
    last_sample_p0 = loudness_valid && (cnt == LastCnt);
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      acc           <= '0;
      cnt           <= '0;
      step_req      <= 1'b0;
      angle_index   <= '0;
      avg_valid     <= 1'b0;
      avg_loudness  <= '0;
      peak_angle    <= '0;
      peak_loudness <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_ACCUM;
            angle_index   <= '0;
            acc           <= '0;
            cnt           <= '0;
            peak_loudness <= '0;
            peak_angle    <= '0;
            busy          <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (last_sample_p0) begin
            avg_loudness <= avg_p0;
            avg_valid    <= 1'b1;
            // Strict compare: on a tie the earlier angle wins.
            if (avg_p0 > peak_loudness) begin
              peak_loudness <= avg_p0;
              peak_angle    <= angle_index;
            end
            if (angle_index < LastAngle) begin
              state    <= S_WAIT;
              step_req <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state    <= S_DONE;
              step_req <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else if (loudness_valid) begin
            acc <= acc_sum_p0;
            cnt <= cnt + CntW'(1);
          end
        end
        S_WAIT: begin
          if (step_ack) begin
            state       <= S_ACCUM;
            step_req    <= 1'b0;
            angle_index <= angle_index + AW'(1);
            acc         <= '0;
            cnt         <= '0;
          end
        end
        S_DONE: begin
          if (continuous) begin
            state         <= S_ACCUM;
            angle_index   <= '0;
            acc           <= '0;
            cnt           <= '0;
            peak_loudness <= '0;
            peak_angle    <= '0;
            busy          <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          step_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
